// File: rtl/ysyx_25020047_lsu.sv
// Load/store unit: accepts one op from execute, runs one valid/ready memory transaction,
// and returns aligned load data (or an error) to write-back via a valid/ready handshake.
module ysyx_25020047_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] inst_type,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] memdata,
  output logic        err
);

  // state  | meaning
  // S_IDLE | waiting for an op from execute
  // S_REQ  | request held on the bus until memory accepts it
  // S_WAIT | waiting for read data / write ack, bounded by TIMEOUT
  // S_DONE | result presented to write-back until consumed
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  localparam logic [31:0] OP_LW  = 32'h0000_0020;
  localparam logic [31:0] OP_LBU = 32'h0000_0040;
  localparam logic [31:0] OP_SW  = 32'h0000_0080;
  localparam logic [31:0] OP_SB  = 32'h0000_0100;
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        is_lw_q, is_lw_d;
  logic        is_lbu_q, is_lbu_d;
  logic [1:0]  off_q, off_d;
  logic        mem_wen_q, mem_wen_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wmask_q, mem_wmask_d;
  logic [31:0] memdata_q, memdata_d;
  logic        err_q, err_d;

  logic op_lw, op_lbu, op_sw, op_sb, op_mem, misaligned;

  always_comb begin
    op_lw      = (inst_type == OP_LW);
    op_lbu     = (inst_type == OP_LBU);
    op_sw      = (inst_type == OP_SW);
    op_sb      = (inst_type == OP_SB);
    op_mem     = op_lw | op_lbu | op_sw | op_sb;
    misaligned = (op_lw | op_sw) & (addr[1:0] != 2'b00);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_lw_d     = is_lw_q;
    is_lbu_d    = is_lbu_q;
    off_d       = off_q;
    mem_wen_d   = mem_wen_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    memdata_d   = memdata_q;
    err_d       = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          is_lw_d     = op_lw;
          is_lbu_d    = op_lbu;
          off_d       = addr[1:0];
          mem_wen_d   = op_sw | op_sb;
          mem_addr_d  = {addr[31:2], 2'b00};
          mem_wdata_d = op_sb ? {4{wdata[7:0]}} : (op_sw ? wdata : 32'h0);
          mem_wmask_d = op_sw ? 4'hF : (op_sb ? (4'b0001 << addr[1:0]) : 4'h0);
          memdata_d   = 32'h0;
          err_d       = 1'b0;
          if (!op_mem) begin
            state_d = S_DONE;
          end else if (misaligned) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          cnt_d   = 16'h0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // a response on the final counted cycle still wins over the timeout
        if (mem_rsp_valid) begin
          err_d   = 1'b0;
          state_d = S_DONE;
          if (is_lw_q)       memdata_d = mem_rdata;
          else if (is_lbu_q) memdata_d = {24'h0, mem_rdata[{off_q, 3'b000} +: 8]};
          else               memdata_d = 32'h0;
        end else if (cnt_q == CNT_LAST) begin
          err_d     = 1'b1;
          memdata_d = 32'h0;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 16'h0;
      is_lw_q     <= 1'b0;
      is_lbu_q    <= 1'b0;
      off_q       <= 2'b00;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_wmask_q <= 4'h0;
      memdata_q   <= 32'h0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_lw_q     <= is_lw_d;
      is_lbu_q    <= is_lbu_d;
      off_q       <= off_d;
      mem_wen_q   <= mem_wen_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      memdata_q   <= memdata_d;
      err_q       <= err_d;
    end
  end

  assign in_ready      = (state_q == S_IDLE) & ~rst;
  assign mem_req_valid = (state_q == S_REQ);
  assign out_valid     = (state_q == S_DONE);
  assign mem_wen       = mem_wen_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_wmask     = mem_wmask_q;
  assign memdata       = memdata_q;
  assign err           = err_q;

endmodule

// File: tb/tb_ysyx_25020047_lsu.sv
// Scoreboard bench for the LSU: expected results are queued when an op is issued and
// compared when out_valid appears; bus fields and latencies are checked along the way.
module tb_ysyx_25020047_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] inst_type, addr, wdata;
  logic        mem_req_valid, mem_req_ready, mem_wen;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;
  logic        out_valid, out_ready;
  logic [31:0] memdata;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;
  logic [32:0] sb_q[$];

  ysyx_25020047_lsu #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .inst_type(inst_type), .addr(addr), .wdata(wdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .memdata(memdata), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one op at a negedge and drive the memory side; rsp_wait < 0 means never respond.
  task automatic run_op(input logic [31:0] inst, input logic [31:0] a, input logic [31:0] wd,
                        input int req_wait, input int rsp_wait, input logic [31:0] rd,
                        input logic exp_req, input logic [31:0] exp_maddr,
                        input logic [31:0] exp_mwdata, input logic [3:0] exp_mask,
                        input logic exp_wen, input logic [31:0] exp_data, input logic exp_err,
                        input int exp_lat, input int hold);
    int n;
    int lat;
    logic [32:0] e;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1; inst_type = inst; addr = a; wdata = wd;
    sb_q.push_back({exp_err, exp_data});
    @(negedge clk);
    in_valid = 1'b0; inst_type = 32'h0; addr = 32'hFFFF_FFFF; wdata = 32'h0;
    lat = 1;
    chk("in_ready_busy", 32'(in_ready), 32'd0);
    if (exp_req) begin
      for (int i = 0; i <= req_wait; i++) begin
        chk("req_valid", 32'(mem_req_valid), 32'd1);
        chk("req_addr", mem_addr, exp_maddr);
        chk("req_wmask", 32'(mem_wmask), 32'(exp_mask));
        chk("req_wen", 32'(mem_wen), 32'(exp_wen));
        if (exp_wen) chk("req_wdata", mem_wdata, exp_mwdata);
        mem_rsp_valid = 1'b1;  // stray response during REQ must be ignored
        mem_req_ready = (i == req_wait);
        @(negedge clk);
        lat++;
      end
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
    end else begin
      chk("no_req", 32'(mem_req_valid), 32'd0);
    end
    n = 0;
    while (!out_valid && n < 300) begin
      mem_rsp_valid = exp_req && (n == rsp_wait);
      mem_rdata = rd;
      @(negedge clk);
      lat++; n++;
    end
    mem_rsp_valid = 1'b0;
    mem_rdata = 32'h5A5A_5A5A;
    if (!out_valid) begin
      chk("out_valid_wait", 32'(out_valid), 32'd1);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
    end else begin
      if (exp_lat > 0) chk("latency", 32'(lat), 32'(exp_lat));
      chk("sb_nonempty", 32'(sb_q.size()), 32'd1);
      e = sb_q.pop_front();
      for (int h = 0; h <= hold; h++) begin
        chk("out_valid", 32'(out_valid), 32'd1);
        chk("memdata", memdata, e[31:0]);
        chk("err", 32'(err), 32'(e[32]));
        mem_rsp_valid = (h == 0);  // stray response in DONE
        out_ready = (h == hold);
        @(negedge clk);
      end
      out_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      chk("back_idle", 32'(in_ready), 32'd1);
      chk("out_valid_drop", 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; inst_type = 32'h0; addr = 32'h0; wdata = 32'h0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = 32'h0; out_ready = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_wmask", 32'(mem_wmask), 32'd0);
    chk("rst_memdata", memdata, 32'h0);
    chk("rst_err", 32'(err), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // lw best case
    run_op(32'h20, 32'h8000_0104, 32'h0, 0, 0, 32'hDEAD_BEEF, 1'b1, 32'h8000_0104, 32'h0, 4'h0, 1'b0,
           32'hDEAD_BEEF, 1'b0, 3, 0);
    // lbu offsets 3, 1, 0
    run_op(32'h40, 32'h8000_0107, 32'h0, 0, 1, 32'hA1B2_C3D4, 1'b1, 32'h8000_0104, 32'h0, 4'h0, 1'b0,
           32'h0000_00A1, 1'b0, 4, 0);
    run_op(32'h40, 32'h8000_0105, 32'h0, 1, 0, 32'hA1B2_C3D4, 1'b1, 32'h8000_0104, 32'h0, 4'h0, 1'b0,
           32'h0000_00C3, 1'b0, 4, 0);
    run_op(32'h40, 32'h8000_0104, 32'h0, 0, 0, 32'hA1B2_C3D4, 1'b1, 32'h8000_0104, 32'h0, 4'h0, 1'b0,
           32'h0000_00D4, 1'b0, 3, 0);
    // sb with 4 cycles of backpressure
    run_op(32'h100, 32'h8000_0002, 32'h1234_5678, 4, 0, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000,
           32'h7878_7878, 4'b0100, 1'b1, 32'h0, 1'b0, 7, 0);
    // sw aligned
    run_op(32'h80, 32'h8000_0010, 32'hCAFE_F00D, 0, 2, 32'hFFFF_FFFF, 1'b1, 32'h8000_0010,
           32'hCAFE_F00D, 4'hF, 1'b1, 32'h0, 1'b0, 5, 0);
    // misaligned lw held for 3 cycles, misaligned sw, non-memory op
    run_op(32'h20, 32'h8000_0002, 32'h0, 0, 0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0,
           32'h0, 1'b1, 1, 3);
    run_op(32'h80, 32'h8000_0001, 32'h1111_2222, 0, 0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0,
           32'h0, 1'b1, 1, 0);
    run_op(32'h1, 32'h8000_0000, 32'h0, 0, 0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0,
           32'h0, 1'b0, 1, 1);
    // response on the last WAIT cycle wins over the timeout
    run_op(32'h20, 32'h8000_0020, 32'h0, 0, 3, 32'h0BAD_CAFE, 1'b1, 32'h8000_0020, 32'h0, 4'h0, 1'b0,
           32'h0BAD_CAFE, 1'b0, 6, 0);
    // timeout: no response in 4 WAIT cycles
    run_op(32'h20, 32'h8000_0030, 32'h0, 0, -1, 32'h0, 1'b1, 32'h8000_0030, 32'h0, 4'h0, 1'b0,
           32'h0, 1'b1, 6, 0);

    // late response in IDLE is ignored
    mem_rsp_valid = 1'b1; mem_rdata = 32'h1234_5678;
    repeat (2) begin
      @(negedge clk);
      chk("late_rsp_out_valid", 32'(out_valid), 32'd0);
      chk("late_rsp_in_ready", 32'(in_ready), 32'd1);
    end
    mem_rsp_valid = 1'b0;

    // reset while in REQ drops mem_req_valid asynchronously
    in_valid = 1'b1; inst_type = 32'h20; addr = 32'h8000_0040;
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_rst_req_valid", 32'(mem_req_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_req_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_req_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // reset while in WAIT
    in_valid = 1'b1; inst_type = 32'h20; addr = 32'h8000_0050;
    @(negedge clk);
    in_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("wait_req_valid", 32'(mem_req_valid), 32'd0);
    chk("wait_in_ready", 32'(in_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("rst_wait_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_wait_out_valid", 32'(out_valid), 32'd0);
    chk("rst_wait_mem_addr", mem_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("post_rst_idle_out_valid", 32'(out_valid), 32'd0);

    // normal lw after reset
    run_op(32'h20, 32'h8000_0060, 32'h0, 0, 0, 32'h7654_3210, 1'b1, 32'h8000_0060, 32'h0, 4'h0, 1'b0,
           32'h7654_3210, 1'b0, 3, 0);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ysyx_25020047_lsu.md
# ysyx_25020047_lsu

Load/store unit for the NPC core. It takes one memory operation from the execute stage and drives it over a valid/ready request bus to data memory. It waits for the response, then aligns and extracts the read data. The result is handed to the write-back stage as `memdata` with a valid/ready handshake. It is the producer end of the `memdata` path that write-back consumes, and it supports multi-cycle and variable-latency memory.

## Interface
- `TIMEOUT`, default 255: max cycles spent in WAIT before abort with error; must be ≥ 1 and < 2^16.
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  execute stage presents an operation
- `in_ready`  out  1  LSU can accept; high only in IDLE with rst low
- `inst_type`  in  32  one-hot op: 0x20 lw, 0x40 lbu, 0x80 sw, 0x100 sb; any other value = non-memory op
- `addr`  in  32  byte address (EXU result)
- `wdata`  in  32  store data (rs2)
- `mem_req_valid`  out  1  request to memory
- `mem_req_ready`  in  1  memory accepts request
- `mem_wen`  out  1  1 = write
- `mem_addr`  out  32  `{addr[31:2],2'b00}`
- `mem_wdata`  out  32  store data, replicated for sb
- `mem_wmask`  out  4  byte enables (0 for reads)
- `mem_rsp_valid`  in  1  read data / write ack; always accepted in WAIT
- `mem_rdata`  in  32  read word
- `out_valid`  out  1  result ready for write-back
- `out_ready`  in  1  write-back consumes result
- `memdata`  out  32  extracted load data; 0 for stores, non-memory ops, and errors
- `err`  out  1  misaligned access or timeout, qualified by `out_valid`

## Operation
- **States:** IDLE, REQ, WAIT, DONE. Reset state is IDLE.
- **IDLE:** on `in_valid & in_ready`, latch `inst_type`, `addr`, and `wdata`.
  - Memory op, aligned → REQ.
  - Non-memory op → DONE with `memdata`=0, `err`=0.
  - lw or sw with `addr[1:0]`≠0 → DONE with `err`=1, `memdata`=0, and no bus request.
  - Byte ops are never misaligned.
- **REQ:** `mem_req_valid`=1, with `mem_wen`, `mem_addr`, `mem_wdata`, and `mem_wmask` stable. Stay until `mem_req_ready` is high, then go to WAIT and clear the counter. `mem_rsp_valid` in REQ is ignored.
- **WAIT:** the counter increments every cycle.
  - On `mem_rsp_valid`, capture the result → DONE, `err`=0.
  - lw: `memdata` = `mem_rdata`.
  - lbu: `memdata` = `{24'b0, mem_rdata[8*addr[1:0] +: 8]}`.
  - sw, sb: `memdata` = 0.
  - If the counter reaches TIMEOUT with no response → DONE, `err`=1, `memdata`=0.
  - A response in the same cycle the counter reaches TIMEOUT wins, and `err`=0.
- **DONE:** `out_valid`=1. `memdata` and `err` are held stable until `out_ready`, then → IDLE.
- **Store encoding:**
  - sw: `mem_wmask`=4'hF, `mem_wdata`=`wdata`.
  - sb: `mem_wmask`=4'b0001<<`addr[1:0]`, `mem_wdata`=`{4{wdata[7:0]}}`.
- **Reads:** `mem_wen`=0, `mem_wmask`=0.
- **Stray responses:** `mem_rsp_valid` in IDLE or DONE is ignored. A response that arrives after a timeout is dropped.

## Timing
- **Reset values:** `in_ready`=0 while `rst` is high. `mem_req_valid`, `mem_wen`, `mem_addr`, `mem_wdata`, `mem_wmask`, `out_valid`, `memdata`, and `err` are all 0. Counter is 0.
- **Reset mid-operation:** aborts immediately (asynchronous). `mem_req_valid` and `out_valid` drop in the same cycle.
- **Best-case memory op latency:** accept at edge 0, REQ in cycle 1 with `mem_req_ready` high, WAIT in cycle 2 with `mem_rsp_valid` high, `out_valid` in cycle 3. That is 3 cycles from accept to `out_valid`.
- **Non-memory op or misaligned op:** `out_valid` the cycle after accept.
- **Throughput:** one operation in flight. `in_ready` is low from accept until the cycle after the `out_valid & out_ready` handshake.
- **Output registers:** all memory-bus and result outputs are driven from registers or state; there are no combinational paths from inputs to outputs. `in_ready` decodes the state and `rst` only.

## Test plan
- **lw:** lw at `addr`=0x80000104, memory ready immediately, `mem_rdata`=0xDEADBEEF one cycle later → `mem_addr`=0x80000104, `mem_wmask`=0. `out_valid` at accept+3 with `memdata`=0xDEADBEEF, `err`=0.
- **lbu:** lbu at `addr`=0x80000107, `mem_rdata`=0xA1B2C3D4 → `mem_addr`=0x80000104, `memdata`=0x000000A1. Repeat with offset 1 → 0x000000C3.
- **sb with backpressure:** sb at `addr`=0x80000002, `wdata`=0x12345678, `mem_req_ready` low for 4 cycles. `mem_req_valid` and all fields are held. `mem_wmask`=4'b0100, `mem_wdata`=0x78787878. After the write ack, `memdata`=0 and `err`=0.
- **Misaligned lw:** lw at 0x80000002 → `mem_req_valid` never asserts, `out_valid` at accept+1 with `err`=1. Hold `out_ready` low for 3 cycles → `out_valid`, `memdata`, and `err` stay stable.
- **Timeout:** TIMEOUT=4, no `mem_rsp_valid` → `out_valid` with `err`=1, `memdata`=0 after 4 WAIT cycles. A late `mem_rsp_valid` in IDLE is ignored.
- **Reset in WAIT:** assert `rst` during WAIT → `mem_req_valid` and `out_valid` go to 0 immediately and the state returns to IDLE. Following the reset, a new lw completes normally.
